// File: rtl/tempo_pkg.sv
// Shared tempo definitions: default clock/width, tap FSM states and helpers
// used by both the tap-tempo input and the beat generator.
package tempo_pkg;

  localparam int unsigned TEMPO_FREQ     = 24_000_000;
  localparam int unsigned TEMPO_PERIOD_W = 26;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2
  } tap_state_e;

  // Beat period in clock cycles for a given tempo.
  function automatic int unsigned bpm_to_cycles(input int unsigned bpm,
                                                input int unsigned freq = TEMPO_FREQ);
    longint unsigned c;
    c = (64'(freq) * 64'd60) / 64'(bpm);
    return 32'(c);
  endfunction

  // Active-low rotating tap indicator; anything outside the cycle restarts it.
  function automatic logic [2:0] led_step(input logic [2:0] led);
    case (led)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer. The output
// level only moves after the synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; released (1) after reset.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 240_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the raw button into the clock domain (idle-high).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], din};
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // Debounce state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/tap_tempo.sv
// Tap-tempo front end: debounced button press -> tap events, interval
// measurement, 4-deep interval history and averaged beat period.
module tap_tempo
  import tempo_pkg::*;
#(
  parameter int unsigned FREQ            = TEMPO_FREQ,
  parameter int unsigned DEBOUNCE_CYCLES = FREQ / 100,
  parameter int unsigned MIN_INTERVAL    = bpm_to_cycles(300, FREQ),
  parameter int unsigned TIMEOUT_CYCLES  = 2 * FREQ,
  parameter int unsigned PERIOD_W        = TEMPO_PERIOD_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                tap_n,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic [2:0]          led
);

  localparam logic [PERIOD_W-1:0] TMO  = PERIOD_W'(TIMEOUT_CYCLES);
  localparam logic [PERIOD_W-1:0] MINI = PERIOD_W'(MIN_INTERVAL);
  localparam int unsigned         SW   = PERIOD_W + 2;

  logic lvl, lvl_q, tap_evt;

  tap_state_e                state_q, state_d;
  logic [PERIOD_W-1:0]       icnt_q, icnt_d;
  logic [3:0][PERIOD_W-1:0]  h_q, h_d;
  logic [2:0]                n_q, n_d, n_push;
  logic [PERIOD_W-1:0]       period_q, period_d;
  logic                      pv_q, pv_d;
  logic                      locked_q, locked_d;
  logic [2:0]                led_q, led_d;
  logic [SW-1:0]             s2, s4;
  logic [PERIOD_W-1:0]       avg;
  logic                      timeout;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (tap_n),
    .level     (lvl)
  );

  // Previous debounced level for press-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) lvl_q <= 1'b1;
    else            lvl_q <= lvl;
  end

  assign tap_evt = lvl_q & ~lvl;

  // Average of the history as it will look after pushing icnt_q.
  always_comb begin
    n_push = (n_q == 3'd4) ? 3'd4 : n_q + 3'd1;
    s2     = SW'(icnt_q) + SW'(h_q[0]);
    s4     = s2 + SW'(h_q[1]) + SW'(h_q[2]);
    if (n_push == 3'd1)      avg = icnt_q;
    else if (n_push <= 3'd3) avg = PERIOD_W'(s2 >> 1);
    else                     avg = PERIOD_W'(s4 >> 2);
  end

  // Tap FSM: next state, history, interval counter and outputs.
  always_comb begin
    state_d  = state_q;
    icnt_d   = (icnt_q == TMO) ? icnt_q : icnt_q + 1'b1;
    h_d      = h_q;
    n_d      = n_q;
    period_d = period_q;
    pv_d     = 1'b0;
    locked_d = locked_q;
    led_d    = led_q;
    timeout  = (state_q != ST_IDLE) && (icnt_q == TMO);

    if (timeout) begin
      // Abandon the sequence; a coincident tap starts a fresh one.
      state_d  = ST_IDLE;
      h_d      = '0;
      n_d      = '0;
      locked_d = 1'b0;
      led_d    = 3'b111;
      if (tap_evt) begin
        state_d = ST_MEASURE;
        icnt_d  = PERIOD_W'(1);
        led_d   = led_step(3'b111);
      end
    end else if (tap_evt) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_MEASURE;
          icnt_d  = PERIOD_W'(1);
          led_d   = led_step(led_q);
        end
        ST_MEASURE, ST_TRACK: begin
          // Taps faster than the minimum interval are ignored outright.
          if (icnt_q >= MINI) begin
            state_d  = ST_TRACK;
            icnt_d   = PERIOD_W'(1);
            h_d      = {h_q[2:0], icnt_q};
            n_d      = n_push;
            period_d = avg;
            pv_d     = 1'b1;
            locked_d = 1'b1;
            led_d    = led_step(led_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Tap FSM state and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      icnt_q   <= '0;
      h_q      <= '0;
      n_q      <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      led_q    <= 3'b111;
    end else begin
      state_q  <= state_d;
      icnt_q   <= icnt_d;
      h_q      <= h_d;
      n_q      <= n_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      led_q    <= led_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign led          = led_q;

endmodule

// File: tb/tb_tap_tempo.sv
// Bench for tap_tempo: directed scenarios plus random tap gaps, checked
// against a tap-level reference model working on press times.
module tb_tap_tempo;

  localparam int PW  = 26;
  localparam int MIN = 200;
  localparam int TMO = 2000;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          tap_n     = 1'b1;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic [2:0]    led;

  tap_tempo #(
    .FREQ(1000), .DEBOUNCE_CYCLES(4), .MIN_INTERVAL(MIN),
    .TIMEOUT_CYCLES(TMO), .PERIOD_W(PW)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .tap_n        (tap_n),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .led          (led)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc  = 0;
  int vcnt = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) if (period_valid === 1'b1) vcnt <= vcnt + 1;

  int compares = 0;
  int fails    = 0;

  // Reference model state (tap-level view).
  bit         m_idle    = 1'b1;
  int         m_ref     = 0;
  int         m_hist[$];
  int         m_period  = 0;
  int         m_vcnt    = 0;
  int         m_led_idx = -1;
  logic [2:0] leds[3]   = '{3'b110, 3'b101, 3'b011};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] m_led();
    return (m_led_idx < 0) ? 3'b111 : leds[m_led_idx];
  endfunction

  task automatic m_start(input int t);
    m_idle    = 1'b0;
    m_ref     = t;
    m_hist.delete();
    m_led_idx = 0;
  endtask

  task automatic m_tap(input int t);
    int gap, n, s;
    if (m_idle) m_start(t);
    else begin
      gap = t - m_ref;
      if (gap >= TMO) m_start(t);
      else if (gap >= MIN) begin
        m_hist.push_front(gap);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        n = m_hist.size();
        if (n == 1)     m_period = m_hist[0];
        else if (n < 4) m_period = (m_hist[0] + m_hist[1]) / 2;
        else begin
          s = 0;
          foreach (m_hist[i]) s += m_hist[i];
          m_period = s / 4;
        end
        m_vcnt++;
        m_led_idx = (m_led_idx + 1) % 3;
        m_ref     = t;
      end
    end
  endtask

  task automatic m_expire(input int t);
    if (!m_idle && (t - m_ref >= TMO)) begin
      m_idle    = 1'b1;
      m_hist.delete();
      m_led_idx = -1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".period"}, 32'(period), 32'(m_period));
    chk({tag, ".valids"}, 32'(vcnt), 32'(m_vcnt));
    chk({tag, ".locked"}, 32'(locked), 32'(m_hist.size() != 0));
    chk({tag, ".led"},    32'(led), 32'(m_led()));
  endtask

  // Clean press starting at the current negedge; next press after gap cycles.
  task automatic press(input int gap, input string tag);
    m_tap(cyc);
    tap_n = 1'b0;
    repeat (20) @(negedge sys_clk);
    tap_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    check_all(tag);
    repeat (gap - 30) @(negedge sys_clk);
  endtask

  task automatic idle_check(input string tag);
    m_expire(cyc);
    check_all(tag);
  endtask

  initial begin
    int g;
    repeat (3) @(negedge sys_clk);
    chk("rst.period", 32'(period), 32'd0);
    chk("rst.valid",  32'(period_valid), 32'd0);
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.led",    32'(led), 32'b111);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Bounce: toggling every 2 cycles never survives the debouncer.
    for (int i = 0; i < 10; i++) begin
      tap_n = ~tap_n;
      repeat (2) @(negedge sys_clk);
    end
    press(2100, "bounce");
    idle_check("bounce_idle");

    // Steady taps.
    for (int i = 0; i < 4; i++) press(500, "steady");
    press(2100, "steady_last");
    idle_check("steady_idle");

    // Averaging over growing history.
    press(400, "avg0"); press(600, "avg1"); press(800, "avg2");
    press(1000, "avg3"); press(2100, "avg4");
    idle_check("avg_idle");

    // Short tap ignored.
    press(500, "short0"); press(150, "short1"); press(350, "short2");
    press(2100, "short3");
    idle_check("timeout");

    // Two taps after a timeout.
    press(300, "retap0"); press(2100, "retap1");
    idle_check("retap_idle");

    // Boundaries: exactly MIN accepted, TMO-1 accepted, exactly TMO times out.
    press(MIN, "b0"); press(TMO - 1, "bmin"); press(TMO, "bmax");
    press(300, "bnew"); press(2100, "bnew2");
    idle_check("b_idle");

    // Random tap gaps.
    for (int i = 0; i < 25; i++) begin
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 250))
                                      : int'($urandom_range(60, 2300));
      press(g, "rand");
    end
    repeat (2100) @(negedge sys_clk);
    idle_check("rand_idle");

    // Reset in the middle of tracking.
    press(500, "trk0"); press(500, "trk1"); press(250, "trk2");
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mrst.period", 32'(period), 32'd0);
    chk("mrst.valid",  32'(period_valid), 32'd0);
    chk("mrst.locked", 32'(locked), 32'd0);
    chk("mrst.led",    32'(led), 32'b111);
    m_idle = 1'b1; m_hist.delete(); m_period = 0; m_led_idx = -1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    press(400, "post0"); press(2100, "post1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
